// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one radix-2 step per cycle: shift-add multiply or restoring divide
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            last_o
);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    sum, shl, diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl  = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, b_q};
    // partial remainder stays below 2*divisor, so bit XLEN of diff is its sign
    ge   = ~diff[XLEN];

    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_i) begin
        hi_d = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ge};
      end else begin
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CNT_W'(XLEN-1));

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M sequencer: FSM, operand sign handling, special cases, result fix-up
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_in, op_q, op_d;
  logic              neg_q, neg_d, neg_in, load;
  logic              a_signed, b_signed, special, iter_last;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   a_abs, b_abs, special_res, hi, lo, fix_res;
  logic [2*XLEN-1:0] prod;

  assign op_in = muldiv_op_e'(i_funct3);

  always_comb begin
    a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_abs    = (a_signed && i_operand_a[XLEN-1]) ? -i_operand_a : i_operand_a;
    b_abs    = (b_signed && i_operand_b[XLEN-1]) ? -i_operand_b : i_operand_b;
    // remainder follows the dividend only; divisor sign is irrelevant for REM
    neg_in   = (a_signed & i_operand_a[XLEN-1]) ^
               (b_signed & i_operand_b[XLEN-1] & (op_in != OP_REM));

    special     = 1'b0;
    special_res = '0;
    if (i_funct3[2] && i_operand_b == '0) begin
      special     = 1'b1;
      special_res = i_funct3[1] ? i_operand_a : DIV0_Q;
    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                 i_operand_a == OVF_Q && i_operand_b == '1) begin
      special     = 1'b1;
      special_res = (op_in == OP_DIV) ? OVF_Q : '0;
    end
  end

  always_comb begin
    prod = neg_q ? -{hi, lo} : {hi, lo};
    case (op_q)
      OP_MUL:                        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = neg_q ? -lo : lo;
      default:                       fix_res = neg_q ? -hi : hi;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    load     = 1'b0;
    o_stall  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_stall = i_start & (~i_kill | special);
        if (i_start && !i_kill) begin
          op_d  = op_in;
          neg_d = neg_in;
          if (special) begin
            state_d  = ST_DONE;
            result_d = special_res;
          end else begin
            state_d = ST_CALC;
            load    = 1'b1;
          end
        end
      end
      ST_CALC: begin
        o_stall = ~i_kill;
        if (i_kill)         state_d = ST_IDLE;
        else if (iter_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        o_stall = ~i_kill;
        if (i_kill) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_DONE;
          result_d = fix_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  muldiv_iter u_iter (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .load_i (load),
    .en_i   (state_q == ST_CALC),
    .div_i  (op_q[2]),
    .a_i    (a_abs),
    .b_i    (b_abs),
    .hi_o   (hi),
    .lo_o   (lo),
    .last_o (iter_last)
  );

  assign o_done   = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  funct3;
  logic [31:0] opa, opb;
  logic        stall, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int          m_left = -1;
  bit          m_done = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_out = '0;

  muldiv_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_kill      (kill),
    .i_funct3    (funct3),
    .i_operand_a (opa),
    .i_operand_b (opb),
    .o_stall     (stall),
    .o_done      (done),
    .o_result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    ub = b;
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return up[31:0];
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * ub; return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // timeline model: cycles remaining until o_done for the operation in flight
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = -1;
      m_done = 0;
      m_out  = '0;
    end else if (m_done) begin
      m_done = 0;
      m_left = -1;
    end else if (m_left > 0 && kill) begin
      m_left = -1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1;
        m_out  = m_res;
      end
    end else if (start && !kill) begin
      m_res = ref_result(funct3, opa, opb);
      if (is_special(funct3, opa, opb)) begin
        m_left = 0;
        m_done = 1;
        m_out  = m_res;
      end else begin
        m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_stall;
      exp_stall = (m_left > 0 && !kill) ||
                  (m_left < 0 && start && (!kill || is_special(funct3, opa, opb)));
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("result", result, m_out);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; funct3 = f; opa = a; opb = b;
    @(posedge clk); #1;
    start = 0; funct3 = ~f; opa = ~a; opb = b ^ 32'h5A5A_0001;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    issue(f, a, b);
    @(negedge clk);
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_lat);
    check({name, "_value"}, result, exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; start = 0; kill = 0; funct3 = 0; opa = 0; opb = 0;
    @(posedge clk); #1;
    chk_en = 1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    run_op("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu_min",    3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu_m1_2",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("divu_by0",     3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu_by0",     3'b111, 32'd100,        32'd0,         32'd100,       0);
    run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op("divu_max_7",   3'b101, 32'hFFFF_FFFF,  32'd7,         32'h2492_4924, 33);

    issue(3'b000, 32'h0001_2345, 32'h0000_0777);
    repeat (10) @(posedge clk);
    #1 kill = 1;
    #2 check("kill_stall_drop", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    kill = 0;
    check("kill_idle_stall", {31'b0, stall}, 32'd0);
    check("kill_idle_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_keeps_result", result, 32'h2492_4924);

    issue(3'b101, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("rst_result", result, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    repeat (40) @(negedge clk);

    run_op("mul_3_5", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
